stage_id: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the IF stage and its IF/ID latch. Decodes the latched instruction, reads the 32x32 register file (written back from WB), resolves `beq`/`j` in ID, and detects load-use and branch-operand hazards. Drives the IF-stage control inputs (PC write, IF/ID write, flush, PC source, jump) and registers all decoded operands and controls into the ID/EX latch.

---
 rtl/stage_id.sv | 228 ++++++++++++++++++++++
 tb/tb_stage_id.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_id.sv
// ---------------------------------------------------------------------------
// stage_id -- instruction-decode stage of a 5-stage MIPS pipeline.
//
// Decodes the IF/ID instruction, reads the 32x32 register file (written from
// WB with same-cycle bypass), resolves beq/j, detects load-use and
// branch-operand hazards, drives the IF control inputs combinationally and
// registers operands + controls into the ID/EX latch.
//
// Ports:
//   clk, rst_n (sync, active-low), enable (global pipeline enable)
//   inInstruction, inPostPc              IF/ID latch contents
//   inRegWrite, inWriteReg, inWriteData  WB write port
//   inEX_*, inMEM_*                      hazard sources from EX and MEM
//   outAddId, PCSrc, Jump, outPCWrite, outIF_IDWrite, outIF_Flush  -> IF
//   outReadData1/2, outSignExt, outRs/Rt/Rd, control bits, outALUOp -> ID/EX
// ---------------------------------------------------------------------------

// Register file: 32x32, r0 hardwired to zero, WB write bypassed to the reads
// so an instruction in ID sees the value being written back this cycle.
module stage_id_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rf_q <= '{default: '0};
    else        rf_q <= rf_d;
  end

  always_comb begin
    rdata1 = rf_q[raddr1];
    rdata2 = rf_q[raddr2];
    if (wr_en && waddr == raddr1) rdata1 = wdata;
    if (wr_en && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end
endmodule

module stage_id (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] inInstruction,
  input  logic [31:0] inPostPc,
  input  logic        inRegWrite,
  input  logic [4:0]  inWriteReg,
  input  logic [31:0] inWriteData,
  input  logic        inEX_MemRead,
  input  logic        inEX_RegWrite,
  input  logic [4:0]  inEX_WriteReg,
  input  logic        inMEM_MemRead,
  input  logic [4:0]  inMEM_WriteReg,
  output logic [31:0] outAddId,
  output logic        PCSrc,
  output logic        Jump,
  output logic        outPCWrite,
  output logic        outIF_IDWrite,
  output logic        outIF_Flush,
  output logic [31:0] outReadData1,
  output logic [31:0] outReadData2,
  output logic [31:0] outSignExt,
  output logic [4:0]  outRs,
  output logic [4:0]  outRt,
  output logic [4:0]  outRd,
  output logic        outRegDst,
  output logic        outALUSrc,
  output logic        outMemRead,
  output logic        outMemWrite,
  output logic        outMemToReg,
  output logic        outRegWrite,
  output logic [1:0]  outALUOp
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext;

  assign op   = inInstruction[31:26];
  assign rs   = inInstruction[25:21];
  assign rt   = inInstruction[20:16];
  assign rd   = inInstruction[15:11];
  assign sext = {{16{inInstruction[15]}}, inInstruction[15:0]};

  logic [31:0] rd1, rd2;

  stage_id_regfile u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (inRegWrite),
    .waddr  (inWriteReg),
    .wdata  (inWriteData),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // Main decoder
  ctl_t ctl;
  logic is_beq, is_j, uses_rs, uses_rt;

  always_comb begin
    ctl = '0;
    unique case (op)
      OP_RTYPE: begin ctl.reg_dst = 1'b1; ctl.reg_write = 1'b1; ctl.alu_op = 2'd2; end
      OP_LW:    begin ctl.alu_src = 1'b1; ctl.mem_read = 1'b1; ctl.mem_to_reg = 1'b1;
                      ctl.reg_write = 1'b1; end
      OP_SW:    begin ctl.alu_src = 1'b1; ctl.mem_write = 1'b1; end
      OP_ADDI:  begin ctl.alu_src = 1'b1; ctl.reg_write = 1'b1; end
      OP_BEQ:   ctl.alu_op = 2'd1;
      default:  ctl = '0;
    endcase
  end

  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign uses_rs = !is_j;
  assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || is_beq;

  // Hazard detection. A beq resolves in ID, so it must also wait for any ALU
  // result still in EX and for a load that has only reached MEM.
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use, br_stall, stall;

  assign ex_hit_rs  = (inEX_WriteReg != 5'd0) && (inEX_WriteReg == rs);
  assign ex_hit_rt  = (inEX_WriteReg != 5'd0) && (inEX_WriteReg == rt);
  assign mem_hit_rs = (inMEM_WriteReg != 5'd0) && (inMEM_WriteReg == rs);
  assign mem_hit_rt = (inMEM_WriteReg != 5'd0) && (inMEM_WriteReg == rt);

  assign load_use = inEX_MemRead && ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt));
  assign br_stall = is_beq && ((inEX_RegWrite && (ex_hit_rs || ex_hit_rt)) ||
                               (inMEM_MemRead && (mem_hit_rs || mem_hit_rt)));
  assign stall    = load_use || br_stall;

  // IF control: combinational, gated by reset and enable; stall beats redirect.
  logic run, advance, taken;

  assign run     = rst_n && enable;
  assign advance = run && !stall;
  assign taken   = advance && is_beq && (rd1 == rd2);

  assign outPCWrite    = advance;
  assign outIF_IDWrite = advance;
  assign PCSrc         = taken;
  assign Jump          = advance && is_j;
  assign outIF_Flush   = taken || (advance && is_j);
  assign outAddId      = inPostPc + {sext[29:0], 2'b00};

  // ID/EX latch. A stall inserts a bubble: controls cleared, data still captured.
  idex_t idex_d, idex_q;

  always_comb begin
    idex_d = idex_q;
    if (enable) begin
      idex_d.ctl  = stall ? '0 : ctl;
      idex_d.rd1  = rd1;
      idex_d.rd2  = rd2;
      idex_d.sext = sext;
      idex_d.rs   = rs;
      idex_d.rt   = rt;
      idex_d.rd   = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign outReadData1 = idex_q.rd1;
  assign outReadData2 = idex_q.rd2;
  assign outSignExt   = idex_q.sext;
  assign outRs        = idex_q.rs;
  assign outRt        = idex_q.rt;
  assign outRd        = idex_q.rd;
  assign outRegDst    = idex_q.ctl.reg_dst;
  assign outALUSrc    = idex_q.ctl.alu_src;
  assign outMemRead   = idex_q.ctl.mem_read;
  assign outMemWrite  = idex_q.ctl.mem_write;
  assign outMemToReg  = idex_q.ctl.mem_to_reg;
  assign outRegWrite  = idex_q.ctl.reg_write;
  assign outALUOp     = idex_q.ctl.alu_op;
endmodule

// File: tb/tb_stage_id.sv
// ---------------------------------------------------------------------------
// tb_stage_id -- self-checking bench for stage_id. Directed steps from the
// block's intended behaviour followed by randomized traffic; every step is
// checked against an architectural model (register array + decode rules).
// ---------------------------------------------------------------------------
module tb_stage_id;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, enable = 1'b1;
  logic [31:0] inInstruction = '0, inPostPc = '0;
  logic        inRegWrite = 1'b0;
  logic [4:0]  inWriteReg = '0;
  logic [31:0] inWriteData = '0;
  logic        inEX_MemRead = 1'b0, inEX_RegWrite = 1'b0;
  logic [4:0]  inEX_WriteReg = '0;
  logic        inMEM_MemRead = 1'b0;
  logic [4:0]  inMEM_WriteReg = '0;
  logic [31:0] outAddId, outReadData1, outReadData2, outSignExt;
  logic        PCSrc, Jump, outPCWrite, outIF_IDWrite, outIF_Flush;
  logic [4:0]  outRs, outRt, outRd;
  logic        outRegDst, outALUSrc, outMemRead, outMemWrite, outMemToReg, outRegWrite;
  logic [1:0]  outALUOp;

  int checks = 0, failures = 0;

  stage_id dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .inInstruction(inInstruction), .inPostPc(inPostPc),
    .inRegWrite(inRegWrite), .inWriteReg(inWriteReg), .inWriteData(inWriteData),
    .inEX_MemRead(inEX_MemRead), .inEX_RegWrite(inEX_RegWrite), .inEX_WriteReg(inEX_WriteReg),
    .inMEM_MemRead(inMEM_MemRead), .inMEM_WriteReg(inMEM_WriteReg),
    .outAddId(outAddId), .PCSrc(PCSrc), .Jump(Jump),
    .outPCWrite(outPCWrite), .outIF_IDWrite(outIF_IDWrite), .outIF_Flush(outIF_Flush),
    .outReadData1(outReadData1), .outReadData2(outReadData2), .outSignExt(outSignExt),
    .outRs(outRs), .outRt(outRt), .outRd(outRd),
    .outRegDst(outRegDst), .outALUSrc(outALUSrc), .outMemRead(outMemRead),
    .outMemWrite(outMemWrite), .outMemToReg(outMemToReg), .outRegWrite(outRegWrite),
    .outALUOp(outALUOp)
  );

  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] m_regs [32];
  logic [31:0] e_rd1 = '0, e_rd2 = '0, e_sx = '0;
  logic [4:0]  e_rs = '0, e_rt = '0, e_rd = '0;
  logic [7:0]  e_ctl = '0;

  task automatic chk(input string tag, input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, nm, obs, exp);
    end
  endtask

  // {RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, ALUOp[1:0]}
  function automatic logic [7:0] ctl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 8'b1000_0110;
      6'h23:   return 8'b0110_1100;
      6'h2B:   return 8'b0101_0000;
      6'h08:   return 8'b0100_0100;
      6'h04:   return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  // Value an instruction in ID sees: WB this cycle wins, r0 is always zero.
  function automatic logic [31:0] rdreg(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (inRegWrite && inWriteReg == r) return inWriteData;
    return m_regs[r];
  endfunction

  // Inputs must already be applied. Checks the IF controls before the edge and
  // the ID/EX latch after it.
  task automatic step(input string tag);
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] sx, r1, r2, x_add;
    logic        isb, isj, urs, urt, ld, br, stall, adv, x_src, x_j;
    op  = inInstruction[31:26];
    rs  = inInstruction[25:21];
    rt  = inInstruction[20:16];
    sx  = {{16{inInstruction[15]}}, inInstruction[15:0]};
    r1  = rdreg(rs);
    r2  = rdreg(rt);
    isb = (op == 6'h04);
    isj = (op == 6'h02);
    urs = !isj;
    urt = (op == 6'h00) || (op == 6'h2B) || isb;
    ld  = inEX_MemRead && inEX_WriteReg != 0 &&
          ((urs && inEX_WriteReg == rs) || (urt && inEX_WriteReg == rt));
    br  = isb && ((inEX_RegWrite && inEX_WriteReg != 0 && (inEX_WriteReg == rs || inEX_WriteReg == rt)) ||
                  (inMEM_MemRead && inMEM_WriteReg != 0 && (inMEM_WriteReg == rs || inMEM_WriteReg == rt)));
    stall = ld || br;
    adv   = rst_n && enable && !stall;
    x_src = adv && isb && (r1 == r2);
    x_j   = adv && isj;
    x_add = inPostPc + sx * 4;
    @(negedge clk);
    chk(tag, "pcw",   {31'd0, outPCWrite},    {31'd0, adv});
    chk(tag, "ifidw", {31'd0, outIF_IDWrite}, {31'd0, adv});
    chk(tag, "pcsrc", {31'd0, PCSrc},         {31'd0, x_src});
    chk(tag, "jump",  {31'd0, Jump},          {31'd0, x_j});
    chk(tag, "flush", {31'd0, outIF_Flush},   {31'd0, x_src || x_j});
    chk(tag, "addid", outAddId, x_add);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      {e_rd1, e_rd2, e_sx, e_rs, e_rt, e_rd, e_ctl} = '0;
    end else begin
      if (inRegWrite && inWriteReg != 0) m_regs[inWriteReg] = inWriteData;
      if (enable) begin
        e_rd1 = r1; e_rd2 = r2; e_sx = sx;
        e_rs = rs; e_rt = rt; e_rd = inInstruction[15:11];
        e_ctl = stall ? 8'd0 : ctl_of(op);
      end
    end
    chk(tag, "rd1", outReadData1, e_rd1);
    chk(tag, "rd2", outReadData2, e_rd2);
    chk(tag, "sx",  outSignExt,   e_sx);
    chk(tag, "idx", {17'd0, outRs, outRt, outRd}, {17'd0, e_rs, e_rt, e_rd});
    chk(tag, "ctl", {24'd0, outRegDst, outALUSrc, outMemRead, outMemWrite,
                     outMemToReg, outRegWrite, outALUOp}, {24'd0, e_ctl});
  endtask

  task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    inRegWrite = we; inWriteReg = r; inWriteData = d;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    logic [5:0] ops [7];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h08;
    ops[4] = 6'h04; ops[5] = 6'h02; ops[6] = 6'h3F;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    #1;

    // Reset, then write r5, then reset again for two cycles
    step("rst0"); step("rst1");
    rst_n = 1'b1; inInstruction = itype(6'h3F, 0, 0, 0); wb(1, 5, 32'h5555_AAAA);
    step("wr5");
    rst_n = 1'b0; wb(0, 0, 0); inInstruction = rtype(5, 5, 1);
    step("rst2"); step("rst3");
    rst_n = 1'b1;
    step("rd5");
    chk("rd5", "r5zero", outReadData1, 32'h0);

    // WB bypass into same-cycle decode
    wb(1, 3, 32'h1234); inInstruction = rtype(3, 3, 1);
    step("byp");
    chk("byp", "rd1", outReadData1, 32'h1234);
    chk("byp", "rd2", outReadData2, 32'h1234);
    wb(1, 0, 32'hFFFF_FFFF); inInstruction = rtype(0, 3, 2);
    step("wr0");
    wb(0, 0, 0); step("rd0");
    chk("rd0", "r0", outReadData1, 32'h0);

    // r1 = r2 = 7; load-use on r2
    wb(1, 1, 7); inInstruction = itype(6'h3F, 0, 0, 0); step("wr1");
    wb(1, 2, 7); step("wr2");
    wb(0, 0, 0);
    inEX_MemRead = 1; inEX_RegWrite = 1; inEX_WriteReg = 2; inInstruction = rtype(2, 1, 4);
    #1 chk("lu", "pcw0", {31'd0, outPCWrite}, 32'd0);
    step("lu");
    inEX_MemRead = 0; inEX_RegWrite = 0; inEX_WriteReg = 0;
    step("lu_go");

    // beq taken / not taken
    inPostPc = 32'h100; inInstruction = itype(6'h04, 1, 2, 16'd3);
    #1 chk("beq", "tgt", outAddId, 32'h10C);
    chk("beq", "pcsrc1", {31'd0, PCSrc}, 32'd1);
    step("beq_t");
    wb(1, 2, 8); step("wr2b");
    wb(0, 0, 0); step("beq_nt");

    // jump, undefined op, negative offset
    inInstruction = {6'h02, 26'h0ABCDEF}; step("j");
    inInstruction = itype(6'h3F, 1, 2, 16'h8000); step("nop3f");

    // beq on r6 with load in MEM: stall despite equal operands
    wb(1, 6, 32'h66); inInstruction = itype(6'h3F, 0, 0, 0); step("wr6");
    wb(0, 0, 0); inMEM_MemRead = 1; inMEM_WriteReg = 6;
    inInstruction = itype(6'h04, 6, 6, 16'hFFFF); step("bstl");
    inMEM_MemRead = 0; inMEM_WriteReg = 0;
    inInstruction = itype(6'h23, 6, 7, 16'h10); step("lw");
    enable = 0; inInstruction = rtype(1, 2, 9); wb(1, 9, 32'h99); step("en0");
    step("en0b");
    enable = 1; wb(0, 0, 0); step("en1");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst_n          = ($urandom_range(0, 39) != 0);
      enable         = ($urandom_range(0, 7) != 0);
      inInstruction  = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 16'($urandom)};
      inPostPc       = $urandom & 32'hFFFF_FFFC;
      wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom_range(0, 3));
      inEX_MemRead   = ($urandom_range(0, 3) == 0);
      inEX_RegWrite  = ($urandom_range(0, 1) == 1);
      inEX_WriteReg  = 5'($urandom_range(0, 7));
      inMEM_MemRead  = ($urandom_range(0, 3) == 0);
      inMEM_WriteReg = 5'($urandom_range(0, 7));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
